// File: rtl/uart_tx_serializer_if.sv
// System-side bundle for the UART transmitter: the parallel byte with its
// framing options, the valid/busy handshake, and the serial line.
// The master is the byte producer and the slave is the serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PS_WIDTH   = 6
) ();
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [PS_WIDTH-1:0]   prescale;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        output prescale,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        input  prescale,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter running on the RX oversampling clock.
// Each frame is a start bit, DATA_WIDTH data bits LSB first, an optional
// parity bit and one stop bit. Every bit is held for P clk cycles, where P is
// the prescale captured when the byte was accepted (8, 16 or 32; anything
// else falls back to 16). tx_out and busy come straight from flops.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PS_WIDTH   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_serializer_if.slave  bus
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                r_state;
    logic [PS_WIDTH-1:0]   r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [PS_WIDTH-1:0]   r_ps;
    logic                  r_tx_out;
    logic                  r_busy;

    state_t                w_state_next;
    logic [PS_WIDTH-1:0]   w_cnt_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_par_en_next;
    logic                  w_par_typ_next;
    logic [PS_WIDTH-1:0]   w_ps_next;
    logic                  w_tx_out_next;
    logic                  w_busy_next;

    logic [PS_WIDTH-1:0]   w_ps_eff;
    logic [PS_WIDTH-1:0]   w_ps_last;
    logic                  w_bit_end;
    logic [IDX_W-1:0]      w_idx_inc;
    logic                  w_parity;

    // Map the incoming prescale onto a supported bit period; illegal values
    // are normalised once at acceptance so the frame logic only sees 8/16/32.
    always_comb begin
        w_ps_eff = PS_WIDTH'(16);
        if (bus.prescale == PS_WIDTH'(8) || bus.prescale == PS_WIDTH'(16) ||
            bus.prescale == PS_WIDTH'(32)) begin
            w_ps_eff = bus.prescale;
        end
    end

    assign w_ps_last = r_ps - PS_WIDTH'(1);
    assign w_bit_end = (r_cnt == w_ps_last);
    assign w_idx_inc = r_idx + IDX_W'(1);
    // Even parity when par_typ=0, odd when par_typ=1, from the held byte only.
    assign w_parity  = (^r_data) ^ r_par_typ;

    // Next-state logic: bit-period counting, bit sequencing and the next
    // value of the registered serial line and busy flag.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = w_bit_end ? '0 : r_cnt + PS_WIDTH'(1);
        w_idx_next     = r_idx;
        w_data_next    = r_data;
        w_par_en_next  = r_par_en;
        w_par_typ_next = r_par_typ;
        w_ps_next      = r_ps;
        w_tx_out_next  = r_tx_out;
        w_busy_next    = r_busy;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next    = '0;
                w_idx_next    = '0;
                w_tx_out_next = 1'b1;
                w_busy_next   = 1'b0;
                if (bus.data_valid) begin
                    w_data_next    = bus.p_data;
                    w_par_en_next  = bus.par_en;
                    w_par_typ_next = bus.par_typ;
                    w_ps_next      = w_ps_eff;
                    w_state_next   = ST_START;
                    w_tx_out_next  = 1'b0;
                    w_busy_next    = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next  = ST_DATA;
                    w_idx_next    = '0;
                    w_tx_out_next = r_data[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_LAST) begin
                        if (r_par_en) begin
                            w_state_next  = ST_PARITY;
                            w_tx_out_next = w_parity;
                        end else begin
                            w_state_next  = ST_STOP;
                            w_tx_out_next = 1'b1;
                        end
                    end else begin
                        w_idx_next    = w_idx_inc;
                        w_tx_out_next = r_data[w_idx_inc];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next  = ST_STOP;
                    w_tx_out_next = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next  = ST_IDLE;
                    w_tx_out_next = 1'b1;
                    w_busy_next   = 1'b0;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_cnt_next    = '0;
                w_tx_out_next = 1'b1;
                w_busy_next   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and parks the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_ps      <= PS_WIDTH'(16);
            r_tx_out  <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_data    <= w_data_next;
            r_par_en  <= w_par_en_next;
            r_par_typ <= w_par_typ_next;
            r_ps      <= w_ps_next;
            r_tx_out  <= w_tx_out_next;
            r_busy    <= w_busy_next;
        end
    end

    assign bus.tx_out = r_tx_out;
    assign bus.busy   = r_busy;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmitter for the TX side of the UART link; it is the counterpart of the oversampling RX path.
- Runs on the same oversampling clock as RX and holds each bit for Prescale clk cycles.
- Accepts one parallel byte per frame from the system side with a valid/busy handshake.
- Emits one frame per byte: start bit, 8 data bits LSB first, optional parity bit, one stop bit.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PS_WIDTH, 6, width of the Prescale input and of the bit-period counter.

Ports:
- clk  input  1  oversampling clock (same domain as UART RX)
- rst_n  input  1  reset, asynchronous, active-low
- p_data  input  DATA_WIDTH  byte to transmit
- data_valid  input  1  p_data valid; sampled only while idle
- par_en  input  1  1 = insert parity bit
- par_typ  input  1  0 = even parity, 1 = odd parity
- prescale  input  PS_WIDTH  clk cycles per bit; legal values 8, 16, 32
- tx_out  output  1  serial line, idle high
- busy  output  1  frame in progress; data_valid ignored while high

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - tx_out=1, busy=0, state=IDLE, counters cleared.
  - A partial frame is abandoned with no glitch low after reset.
- States: IDLE, START, DATA, PARITY, STOP.
- All outputs are registered.
- IDLE:
  - tx_out=1, busy=0.
  - On a clk edge with data_valid=1, latch p_data, par_en, par_typ and prescale, then go to START.
  - tx_out goes 0 and busy goes 1 on that same edge, so the line is low in the cycle after data_valid is sampled.
- Prescale handling:
  - The latched prescale value is used for the whole frame; input changes mid-frame have no effect.
  - Latched values outside {8,16,32} are treated as 16.
- Bit timing:
  - The bit-period counter runs 0..P-1 (P = effective prescale).
  - Each bit, including start and stop, drives tx_out for exactly P clk cycles.
  - The state or bit index advances when the counter reaches P-1, and the counter wraps to 0.
- START: tx_out=0 for P cycles, then go to DATA with bit index 0.
- DATA:
  - tx_out = latched_data[bit_index], LSB first.
  - The 3-bit index increments at each bit boundary.
  - After index 7 completes, go to PARITY if the latched par_en=1, otherwise go to STOP.
- PARITY:
  - tx_out = XOR-reduce(latched_data) XOR latched par_typ.
  - This gives even parity when par_typ=0 and odd parity when par_typ=1.
  - Computed from the latched byte only.
- STOP:
  - tx_out=1 for P cycles.
  - At the end of the final cycle, go to IDLE and set busy=0.
- Frame length: busy is high for exactly 10·P cycles (par_en=0) or 11·P cycles (par_en=1).
- Back-to-back frames:
  - The earliest next acceptance is the first cycle with busy=0.
  - The minimum inter-frame gap is 1 clk cycle of tx_out=1 beyond the stop bit.
  - data_valid held continuously produces frames spaced by 10·P+1 or 11·P+1 cycles.
- data_valid asserted while busy=1 is ignored; there is no queuing and no error flag.
- tx_out never shows X after reset. There is no combinational path from inputs to outputs.

Test Plan:
- Prescale=8, par_en=0, p_data=0xA5, single data_valid pulse:
  - tx_out bits 0,1,0,1,0,0,1,0,1,1, each held 8 cycles.
  - busy high for exactly 80 cycles; tx_out low the cycle after acceptance.
- Prescale=16, par_en=1, p_data=0x07:
  - With par_typ=0 the parity bit is 1; with par_typ=1 it is 0.
  - busy high for 176 cycles; 11 bits of 16 cycles each.
- Back-to-back: data_valid held high with 0x3C, then 0xC3, while busy:
  - 0xC3 is ignored until busy=0.
  - The second frame's start bit begins exactly 1 idle-high cycle after the first stop bit ends.
- Async reset asserted in the middle of data bit 4:
  - tx_out=1 and busy=0 immediately.
  - After release, a new 0x55 frame at Prescale=8 is fully correct.
- Prescale=32 with 0xFF gives 32-cycle bits. Prescale=12 with 0x81 gives 16-cycle bits, so the illegal value is treated as 16.
- Prescale and p_data changed from 8 and 0x0F to 32 and 0xF0 mid-frame: the frame completes with the original 8-cycle bits and data 0x0F.
